// File: rtl/aes_pkg.sv
// Shared AES constants and types: byte substitution table, round constants,
// the 32-bit word type and the key-expansion state encoding.
package aes_pkg;

  localparam int DEFAULT_N = 128;
  localparam int DEFAULT_R = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Indices outside 1..10 have no round constant and yield zero.
  function automatic logic [7:0] rcon_byte(input int idx);
    logic [7:0] val;
    val = 8'h00;
    case (idx)
      1:  val = RCON[1];
      2:  val = RCON[2];
      3:  val = RCON[3];
      4:  val = RCON[4];
      5:  val = RCON[5];
      6:  val = RCON[6];
      7:  val = RCON[7];
      8:  val = RCON[8];
      9:  val = RCON[9];
      10: val = RCON[10];
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/key_expansion_128_if.sv
// Key load / round-key read bus of the AES-128 key expansion block.
interface key_expansion_128_if #(
  parameter int N = 128,
  parameter int R = 10
);
  localparam int IW = $clog2(R + 1);

  logic          key_valid;
  logic [N-1:0]  key;
  logic          key_ready;
  logic [IW-1:0] rk_idx;
  logic [N-1:0]  round_key;
  logic          keys_valid;
  logic          busy;

  modport master (
    output key_valid, key, rk_idx,
    input  key_ready, round_key, keys_valid, busy
  );

  modport slave (
    input  key_valid, key, rk_idx,
    output key_ready, round_key, keys_valid, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, a purely combinational table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: one round key per clock, all R+1 keys held
// in a register file readable combinationally by index.
module key_expansion_128
  import aes_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int R = DEFAULT_R
) (
  input logic                clk,
  input logic                rst_n,
  key_expansion_128_if.slave bus
);

  localparam int IW = $clog2(R + 1);
  localparam logic [IW-1:0] R_IDX = IW'(R);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] cnt;
  logic [IW-1:0] prev_idx;
  logic [N-1:0]  rk [0:R];
  logic          accept;
  logic          key_ready;

  logic [N-1:0]  prev_rk;
  logic [N-1:0]  next_rk;
  word_t         w0, w1, w2, w3;
  word_t         rot_word, sub_word, temp_word;
  word_t         n0, n1, n2, n3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Key acceptance is only possible while ready, so a key offered mid-expansion is dropped.
  always_comb begin
    state_next     = state;
    key_ready      = 1'b0;
    bus.busy       = 1'b0;
    bus.keys_valid = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (bus.key_valid) state_next = EXPAND;
      end
      EXPAND: begin
        bus.busy = 1'b1;
        if (cnt == R_IDX) state_next = DONE;
      end
      DONE: begin
        key_ready      = 1'b1;
        bus.keys_valid = 1'b1;
        if (bus.key_valid) state_next = EXPAND;
      end
      default: state_next = IDLE;
    endcase
    accept        = bus.key_valid && key_ready;
    bus.key_ready = key_ready;
  end

  // cnt is never 0 in EXPAND; the guard only keeps the read in range elsewhere.
  assign prev_idx = (cnt == '0) ? '0 : cnt - 1'b1;
  assign prev_rk  = rk[prev_idx];

  assign w0       = prev_rk[127:96];
  assign w1       = prev_rk[95:64];
  assign w2       = prev_rk[63:32];
  assign w3       = prev_rk[31:0];
  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .byte_val (rot_word[8*b +: 8]),
      .sub_val  (sub_word[8*b +: 8])
    );
  end

  assign temp_word = sub_word ^ {rcon_byte(int'(cnt)), 24'h000000};
  assign n0        = w0 ^ temp_word;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign next_rk   = {n0, n1, n2, n3};

  // cnt holds at R on the final write so it never wraps past the key file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i <= R; i++) begin
        rk[i] <= '0;
      end
    end else if (accept) begin
      rk[0] <= bus.key;
      cnt   <= IW'(1);
    end else if (state == EXPAND) begin
      rk[cnt] <= next_rk;
      if (cnt != R_IDX) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    bus.round_key = '0;
    if (bus.rk_idx <= R_IDX) bus.round_key = rk[bus.rk_idx];
  end

endmodule

// File: tb/tb_key_expansion_128.sv
// Directed, table-driven bench for key_expansion_128 using FIPS-197 reference
// round keys, plus ignored-key, restart and mid-expansion reset sequences.
module tb_key_expansion_128;

  localparam int N = 128;
  localparam int R = 10;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
    bit           inject;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [3];

  key_expansion_128_if #(.N(N), .R(R)) kif ();

  key_expansion_128 #(.N(N), .R(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [127:0] key_val);
    kif.key_valid = valid;
    kif.key       = key_val;
  endtask

  task automatic check_rk(input string name, input int idx, input logic [127:0] expected);
    kif.rk_idx = 4'(idx);
    #1;
    check_output($sformatf("%s rk[%0d]", name, idx), kif.round_key, expected);
  endtask

  task automatic check_flags(input string name, input logic ready, input logic busy,
                             input logic valid);
    check_output({name, " key_ready"}, 128'(kif.key_ready), 128'(ready));
    check_output({name, " busy"}, 128'(kif.busy), 128'(busy));
    check_output({name, " keys_valid"}, 128'(kif.keys_valid), 128'(valid));
  endtask

  initial begin
    int cycles;
    checks   = 0;
    failures = 0;
    vecs[0] = '{name: "fips",   key: FIPS_KEY, rk1: FIPS_RK1, rk10: FIPS_RK10, inject: 1'b0};
    vecs[1] = '{name: "zero",   key: '0,       rk1: ZERO_RK1, rk10: ZERO_RK10, inject: 1'b0};
    vecs[2] = '{name: "ignore", key: FIPS_KEY, rk1: FIPS_RK1, rk10: FIPS_RK10, inject: 1'b1};

    rst_n      = 1'b0;
    kif.rk_idx = '0;
    apply_stimulus(1'b1, FIPS_KEY);
    repeat (3) tick();
    check_flags("reset", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check_rk("reset", i, '0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, '0);
    tick();
    check_flags("idle", 1'b1, 1'b0, 1'b0);

    // Each vector after the first is accepted from DONE, exercising restart.
    for (int v = 0; v < 3; v++) begin
      apply_stimulus(1'b1, vecs[v].key);
      kif.rk_idx = '0;
      tick();
      apply_stimulus(1'b0, '1);
      check_flags({vecs[v].name, " accept"}, 1'b0, 1'b1, 1'b0);
      check_rk({vecs[v].name, " expand"}, 0, vecs[v].key);
      cycles = 0;
      while (!kif.keys_valid && cycles < 50) begin
        if (vecs[v].inject && cycles == 3) apply_stimulus(1'b1, '1);
        else apply_stimulus(1'b0, '0);
        tick();
        cycles++;
        if (cycles == 1) check_rk({vecs[v].name, " early"}, 1, vecs[v].rk1);
      end
      apply_stimulus(1'b0, '0);
      check_output({vecs[v].name, " latency"}, 128'(cycles), 128'(10));
      check_flags({vecs[v].name, " done"}, 1'b1, 1'b0, 1'b1);
      check_rk(vecs[v].name, 0, vecs[v].key);
      check_rk(vecs[v].name, 1, vecs[v].rk1);
      check_rk(vecs[v].name, 10, vecs[v].rk10);
      for (int i = 11; i < 16; i++) check_rk(vecs[v].name, i, '0);
    end

    // Reset during expansion must abort and clear, ignoring the key offered alongside.
    apply_stimulus(1'b1, FIPS_KEY);
    tick();
    apply_stimulus(1'b0, '0);
    repeat (4) tick();
    check_flags("pre-abort", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    apply_stimulus(1'b1, FIPS_KEY);
    tick();
    rst_n = 1'b1;
    apply_stimulus(1'b0, '0);
    check_flags("abort", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= R; i++) check_rk("abort", i, '0);
    tick();
    check_flags("abort idle", 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expansion_128.md
KEY_EXPANSION_128 -- requirements
Module: key_expansion_128

Interface
REQ-001 Parameter N, default 128, key and round-key width in bits.
REQ-002 Parameter R, default 10, number of AES rounds; the block stores R+1 round keys.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 key_valid  input  1  cipher key offered on key.
REQ-006 key  input  N  cipher key; key[127:96] = w0, key[127:120] = FIPS-197 byte 0.
REQ-007 key_ready  output  1  block accepts a new key (IDLE or DONE).
REQ-008 rk_idx  input  $clog2(R+1)  round-key read index, 0..R.
REQ-009 round_key  output  N  stored round key rk[rk_idx]; combinational read.
REQ-010 keys_valid  output  1  all R+1 round keys are valid and stable.
REQ-011 busy  output  1  expansion in progress.

Function
REQ-012 The FSM SHALL have states IDLE, EXPAND and DONE.
REQ-013 Key acceptance SHALL occur on a rising edge where key_valid && key_ready.
- Action: rk[0] <= key; round counter <= 1; state -> EXPAND.
REQ-014 In EXPAND, each edge SHALL compute rk[cnt] from rk[cnt-1] and increment cnt.
- w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[cnt],24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-015 The edge that writes rk[R] SHALL move state to DONE.
- Latency: acceptance at edge E; rk[i] written at edge E+i; keys_valid high after edge E+R (10 cycles at default).
REQ-016 key_ready SHALL be 1 in IDLE and DONE and 0 in EXPAND; busy SHALL be 1 only in EXPAND; keys_valid SHALL be 1 only in DONE.
REQ-017 key_valid during EXPAND SHALL be ignored; expansion continues unaffected.
REQ-018 Acceptance in DONE SHALL restart expansion: keys_valid drops after that edge and rk[0] is overwritten.
REQ-019 round_key for rk_idx > R SHALL be all zeros; reading indices below cnt during EXPAND SHALL return already-written keys.
REQ-020 All XOR/rotate arithmetic SHALL be bitwise on 32-bit words with no carries; Rcon SHALL be indexed 1..R.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, cnt=0 and all rk[] = 0.
- Resulting outputs: key_ready=1, busy=0, keys_valid=0, round_key=0.
REQ-022 Reset asserted mid-EXPAND SHALL abort expansion within that edge; key_valid is ignored while rst_n=0.

Structure
REQ-023 Package aes_pkg SHALL hold the 256-entry S-box table, the Rcon[1:10] table, the word type (32-bit), the state enum and the default N/R constants.
REQ-024 One sub-module aes_sbox (8-bit combinational lookup from aes_pkg) SHALL be instantiated 4 times for SubWord; encryption_128 reuses the same sub-module.

Verification
REQ-025 Reset: rst_n low for 3 cycles -> key_ready=1, busy=0, keys_valid=0, round_key=0 for every idx.
REQ-026 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
- rk[1] = a0fafe1788542cb123a339392a6c7605.
- rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- keys_valid rises exactly 10 cycles after acceptance.
REQ-027 All-zero key:
- rk[1] = 62636363626363636263636362636363.
- rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- rk_idx=11..15 -> 0.
REQ-028 Ignored key: key_valid with a second key at cycle 4 of EXPAND -> ignored; rk[10] still matches the first key.
REQ-029 Restart and abort:
- In DONE, offer the zero key -> keys_valid drops next cycle; zero-key results appear 10 cycles later.
- rst_n low at cycle 5 of EXPAND -> IDLE, rk[] cleared.
